// File: rtl/sobel_mag_dir.sv
// ============================================================================
// sobel_mag_dir : L1 gradient magnitude and 2-bit direction, 3-cycle pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module sobel_mag_dir #(
  parameter logic [9:0] OUT_LEN  = 10'd638,
  parameter logic [8:0] OUT_ROWS = 9'd510,
  parameter int         MAG_W    = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [16:0]      px_data,
  input  logic [16:0]      py_data,
  input  logic             pi_flag,
  output logic [MAG_W-1:0] po_mag,
  output logic [1:0]       po_dir,
  output logic             po_sof,
  output logic             po_eol,
  output logic             po_flag
);

  localparam logic [9:0] H_LAST = OUT_LEN - 10'd1;
  localparam logic [8:0] V_LAST = OUT_ROWS - 9'd1;
  localparam int         EXT_W  = (MAG_W > 18) ? MAG_W : 18;

  // x*53 via shift/add; 53/128 approximates tan(22.5 deg)
  function automatic logic [23:0] mul53(input logic [16:0] x);
    logic [23:0] xe;
    xe = {7'd0, x};
    return (xe << 5) + (xe << 4) + (xe << 2) + xe;
  endfunction

  // position counters
  logic [9:0] cnt_h_q, cnt_h_d;
  logic [8:0] cnt_v_q, cnt_v_d;

  // stage 1
  logic        v1_q, v1_d;
  logic [16:0] ax_q, ax_d;
  logic [16:0] ay_q, ay_d;
  logic        sd1_q, sd1_d;
  logic        sof1_q, sof1_d;
  logic        eol1_q, eol1_d;

  // stage 2
  logic        v2_q, v2_d;
  logic [17:0] sum_q, sum_d;
  logic        k0_q, k0_d;
  logic        k2_q, k2_d;
  logic        sd2_q, sd2_d;
  logic        sof2_q, sof2_d;
  logic        eol2_q, eol2_d;

  // stage 3 / outputs
  logic             flag_q, flag_d;
  logic [MAG_W-1:0] mag_q, mag_d;
  logic [1:0]       dir_q, dir_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;

  logic [EXT_W-1:0] sum_ext;

  always_comb begin
    cnt_h_d = cnt_h_q;
    cnt_v_d = cnt_v_q;
    v1_d    = pi_flag;
    ax_d    = ax_q;
    ay_d    = ay_q;
    sd1_d   = sd1_q;
    sof1_d  = sof1_q;
    eol1_d  = eol1_q;
    if (pi_flag) begin
      // -65536 negates to 1_0000_0000_0000_0000, i.e. 65536 unsigned
      ax_d   = px_data[16] ? (~px_data + 17'd1) : px_data;
      ay_d   = py_data[16] ? (~py_data + 17'd1) : py_data;
      sd1_d  = px_data[16] ^ py_data[16];
      sof1_d = (cnt_h_q == 10'd0) && (cnt_v_q == 9'd0);
      eol1_d = (cnt_h_q == H_LAST);
      if (cnt_h_q == H_LAST) begin
        cnt_h_d = 10'd0;
        cnt_v_d = (cnt_v_q == V_LAST) ? 9'd0 : cnt_v_q + 9'd1;
      end else begin
        cnt_h_d = cnt_h_q + 10'd1;
      end
    end
  end

  always_comb begin
    v2_d   = v1_q;
    sum_d  = sum_q;
    k0_d   = k0_q;
    k2_d   = k2_q;
    sd2_d  = sd2_q;
    sof2_d = sof2_q;
    eol2_d = eol2_q;
    if (v1_q) begin
      sum_d  = {1'b0, ax_q} + {1'b0, ay_q};
      k0_d   = ({ay_q, 7'd0} <= mul53(ax_q));
      k2_d   = (mul53(ay_q) >= {ax_q, 7'd0});
      sd2_d  = sd1_q;
      sof2_d = sof1_q;
      eol2_d = eol1_q;
    end
  end

  assign sum_ext = EXT_W'(sum_q);

  always_comb begin
    flag_d = v2_q;
    mag_d  = mag_q;
    dir_d  = dir_q;
    sof_d  = sof_q;
    eol_d  = eol_q;
    if (v2_q) begin
      mag_d = (|(sum_ext >> MAG_W)) ? {MAG_W{1'b1}} : sum_ext[MAG_W-1:0];
      if (k0_q)       dir_d = 2'd0;
      else if (k2_q)  dir_d = 2'd2;
      else if (!sd2_q) dir_d = 2'd1;
      else            dir_d = 2'd3;
      sof_d = sof2_q;
      eol_d = eol2_q;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
      v1_q    <= 1'b0;
      ax_q    <= '0;
      ay_q    <= '0;
      sd1_q   <= 1'b0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
      v2_q    <= 1'b0;
      sum_q   <= '0;
      k0_q    <= 1'b0;
      k2_q    <= 1'b0;
      sd2_q   <= 1'b0;
      sof2_q  <= 1'b0;
      eol2_q  <= 1'b0;
      flag_q  <= 1'b0;
      mag_q   <= '0;
      dir_q   <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
      v1_q    <= v1_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      sd1_q   <= sd1_d;
      sof1_q  <= sof1_d;
      eol1_q  <= eol1_d;
      v2_q    <= v2_d;
      sum_q   <= sum_d;
      k0_q    <= k0_d;
      k2_q    <= k2_d;
      sd2_q   <= sd2_d;
      sof2_q  <= sof2_d;
      eol2_q  <= eol2_d;
      flag_q  <= flag_d;
      mag_q   <= mag_d;
      dir_q   <= dir_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
    end
  end

  assign po_flag = flag_q;
  assign po_mag  = mag_q;
  assign po_dir  = dir_q;
  assign po_sof  = sof_q;
  assign po_eol  = eol_q;

endmodule

`default_nettype wire

// File: doc/sobel_mag_dir.md
Name: sobel_mag_dir

Overview:
Consumes the signed Sobel gradient pair (Gx, Gy) from the Sobel stage and produces the L1 gradient magnitude and a 2-bit quantised edge direction for each pixel. It sits between the Sobel stage and non-maximum suppression in the Canny chain. The block is fully pipelined: it accepts one pixel per cycle with arbitrary gaps and adds fixed 3-cycle latency. It also counts positions in the gradient frame and tags start-of-frame and end-of-line for the NMS line buffers.

Parameters:
OUT_LEN, 10'd638, gradient pixels per line (640-2)
OUT_ROWS, 9'd510, gradient lines per frame (512-2)
MAG_W, 16, output magnitude width; saturating

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  reset, asynchronous, active-high
px_data  input  17  signed two's-complement Gx
py_data  input  17  signed two's-complement Gy
pi_flag  input  1  px/py valid, single-cycle strobe per pixel
po_mag  output  MAG_W  |Gx|+|Gy|, saturated
po_dir  output  2  0=0°, 1=45°, 2=90°, 3=135°
po_sof  output  1  high with po_flag on the first pixel of a frame
po_eol  output  1  high with po_flag on the last pixel of a line
po_flag  output  1  output valid, one-cycle pulse

Behaviour:
- Reset and interface: one clock. Reset is asynchronous and active-high. All pipeline registers, counters and outputs clear to 0 while sys_rst=1. Reset mid-frame discards in-flight pixels, and the next pi_flag is treated as pixel (0,0).
- Pipeline: valid bit v1→v2→po_flag. po_flag rises exactly 3 cycles after the pi_flag that launched it. Back-to-back pi_flag every cycle gives back-to-back po_flag. No stall or backpressure.
- S1, when pi_flag=1:
  - ax=|px_data| and ay=|py_data|, each 17-bit unsigned. -65536 maps to 65536 with no overflow.
  - sd=px_data[16]^py_data[16], meaning the signs differ.
  - Position tags are latched here.
- S2, when v1=1:
  - sum=ax+ay, 18-bit.
  - k0=(ay<<7) <= (ax*53), 24-bit compare. x*53 is computed with shifts/adds as (x<<5)+(x<<4)+(x<<2)+x; 53/128 approximates tan22.5°.
  - k2=(ay*53) >= (ax<<7).
- S3, when v2=1:
  - po_mag=sum if sum<2^MAG_W, else all ones.
  - po_dir priority: k0→0, else k2→2, else sd=0→1, else 3.
  - gx=gy=0 gives dir 0. gx=0 with gy≠0 gives dir 2. gy=0 gives dir 0.
- Hold: po_mag, po_dir, po_sof and po_eol hold their last value when po_flag=0. po_sof and po_eol are meaningful only while po_flag=1.
- Counters, advancing on pi_flag:
  - cnt_h counts 0..OUT_LEN-1 and wraps to 0.
  - cnt_v increments when cnt_h wraps, counts 0..OUT_ROWS-1, and wraps to 0.
  - Tag sof=(cnt_h==0 && cnt_v==0) and tag eol=(cnt_h==OUT_LEN-1), both sampled before the increment and carried through the pipe with the pixel.
- Boundary: a frame that ends early is not detected. Counters are realigned only by reset. The counter wrap and a new pixel on the same cycle are normal operation with no lost pixel.

Test Plan:
- Reset: sys_rst=1 mid-stream → all outputs 0 asynchronously. After release, the next pixel gives po_sof=1.
- Pure axes: (gx=100, gy=0) → po_mag=100, po_dir=0, po_flag exactly 3 cycles after pi_flag. (0, -200) → 200, dir 2. (0, 0) → 0, dir 0.
- Diagonals: (100, 100) → 200, dir 1. (100, -100) → 200, dir 3. (-100, -100) → dir 1.
- Threshold edge: (128, 53) → dir 0 (6784 = 6784). (128, 54) → dir 1. (53, 128) → dir 2. (53, 127) → dir 1.
- Saturation/extremes: (-65536, -65536) → po_mag=65535, dir 1. (65535, 0) → 65535, dir 0.
- Streaming: 638×510 pixels with pi_flag every cycle, then with random gaps →
  - po_flag count equals pi_flag count with order preserved.
  - po_eol on every 638th output.
  - po_sof only on the 1st output and on the 1st output of the following frame.
